riscv_mem_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the fetch stage (I port) and the MEM stage (D port, loads and stores).
- Sits between the pipelined RISC-V core and the memory.
- Serialises accesses with a three-state FSM and supports a variable number of memory wait states.
- Gives data accesses priority, with a bounded streak so fetch is never starved.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/riscv_arb_streak.sv | 38 +++
 rtl/riscv_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core slice.
// Holds the memory arbiter FSM states, the word-address byte offset, the
// memory command payload and the LW/SW/ALU opcode constants.
package riscv_pkg;

  // Memory arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  // Byte-address bits below the word address
  localparam int unsigned BYTE_OFF = 2;

  localparam int unsigned XLEN = 32;

  // Memory command captured from the winning port
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

  // Major opcodes used by the pipeline decoder
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_ALU = 7'b0110011;

endpackage

// File: rtl/riscv_arb_streak.sv
// Fairness counter for the memory arbiter.
// Counts consecutive D grants made while a fetch waits and raises
// force_fetch_c when the streak limit is hit and fetch is still requesting.
// Ports: clk, rst_n (sync, active-low), d_grant, i_grant, i_req,
//        force_fetch_c (combinational decode of the registered count).
module riscv_arb_streak
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_grant,
  input  logic i_grant,
  input  logic i_req,
  output logic force_fetch_c
);

  localparam int unsigned CNT_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_STREAK);

  logic [CNT_W-1:0] cnt;

  // Saturating streak: only D grants that bypass a waiting fetch count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (i_grant) begin
      cnt <= '0;
    end else if (d_grant) begin
      if (!i_req)              cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end
  end

  assign force_fetch_c = i_req && (cnt == CNT_MAX);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between fetch (I) and
// the MEM stage (D). D has priority with a bounded streak so fetch is never
// starved; accesses are serialised and tolerate any number of wait states.
// Ports: clk, rst_n (sync, active-low)
//        I side : i_req, i_addr -> i_gnt, i_valid, i_rdata
//        D side : d_req, d_we, d_addr, d_wdata -> d_gnt, d_valid, d_rdata
//        Memory : mem_req, mem_we, mem_addr, mem_wdata <- mem_ready, mem_rdata
module riscv_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  arb_state_t state;
  logic       force_fetch_c;
  logic       d_win_c;
  logic       i_win_c;
  mem_cmd_t   win_c;
  logic       unused_addr_bits;

  // Grants only happen from IDLE, so held requests are ignored while busy
  assign d_win_c = (state == IDLE) && d_req && !force_fetch_c;
  assign i_win_c = (state == IDLE) && !d_win_c && i_req;

  // Command from the winning port; fetch is always a read
  always_comb begin
    win_c = '0;
    if (d_win_c) begin
      win_c.we    = d_we;
      win_c.addr  = d_addr;
      win_c.wdata = d_wdata;
    end else begin
      win_c.addr  = i_addr;
    end
  end

  // Byte offset and bits above the memory range are dropped
  assign unused_addr_bits = ^win_c.addr;

  riscv_arb_streak #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_streak (
    .clk           (clk),
    .rst_n         (rst_n),
    .d_grant       (d_win_c),
    .i_grant       (i_win_c),
    .i_req         (i_req),
    .force_fetch_c (force_fetch_c)
  );

  // FSM with registered grants, responses and memory command
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      i_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (d_win_c || i_win_c) begin
            state     <= d_win_c ? BUSY_D : BUSY_I;
            d_gnt     <= d_win_c;
            i_gnt     <= i_win_c;
            mem_req   <= 1'b1;
            mem_we    <= win_c.we;
            mem_addr  <= win_c.addr[ADDR_W+BYTE_OFF-1:BYTE_OFF];
            mem_wdata <= win_c.wdata;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            i_valid <= 1'b1;
            i_rdata <= mem_rdata;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_valid <= 1'b1;
            // Stores complete without disturbing the last load result
            if (!mem_we) d_rdata <= mem_rdata;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them on every i_valid / d_valid.
module tb_riscv_mem_arbiter;
  import riscv_pkg::*;

  localparam int unsigned ADDR_W = 10;

  typedef struct packed {
    logic        st;
    logic [31:0] data;
  } d_exp_t;

  logic              clk;
  logic              rst_n;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_valid;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [31:0]       d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_i[$];
  d_exp_t      exp_d[$];
  logic [31:0] model [0:1023];

  // Memory responder controls
  logic resp_en;
  logic man_ready;
  int   wait_cfg;
  int   busy_cnt;

  riscv_mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .MAX_D_STREAK (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_valid   (i_valid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Memory model: ready after wait_cfg wait states, or manual when disabled
  always @(posedge clk) begin
    #1;
    if (!resp_en) begin
      mem_ready = man_ready;
      busy_cnt  = 0;
    end else if (mem_req) begin
      if (busy_cnt == wait_cfg) begin
        mem_ready = 1'b1;
        mem_rdata = model[mem_addr];
        if (mem_we) model[mem_addr] = mem_wdata;
        busy_cnt  = 0;
      end else begin
        mem_ready = 1'b0;
        busy_cnt  = busy_cnt + 1;
      end
    end else begin
      mem_ready = 1'b0;
      busy_cnt  = 0;
    end
  end

  // Monitor: every valid pulse must match the oldest expected response
  logic [31:0] mon_ei;
  d_exp_t      mon_ed;
  always @(negedge clk) begin
    if (i_valid) begin
      checks++;
      if (exp_i.size() == 0) begin
        failures++;
        $display("FAIL i_valid_unexpected actual=1 expected=0");
      end else begin
        mon_ei = exp_i.pop_front();
        if (i_rdata !== mon_ei) begin
          failures++;
          $display("FAIL i_rdata actual=0x%08h expected=0x%08h", i_rdata, mon_ei);
        end
      end
    end
    if (d_valid) begin
      checks++;
      if (exp_d.size() == 0) begin
        failures++;
        $display("FAIL d_valid_unexpected actual=1 expected=0");
      end else begin
        mon_ed = exp_d.pop_front();
        if (d_rdata !== mon_ed.data) begin
          failures++;
          $display("FAIL d_rdata(store=%0d) actual=0x%08h expected=0x%08h",
                   mon_ed.st, d_rdata, mon_ed.data);
        end
      end
    end
  end

  logic [9:0] exp_order;
  logic       got_i;
  int         n;

  initial begin
    for (int k = 0; k < 1024; k++) model[k] = 32'h0;
    model[0]  = 32'h0000_0093;
    model[1]  = 32'hCAFE_0001;
    model[4]  = 32'h0000_0013;
    model[8]  = 32'hDEAD_BEEF;
    rst_n     = 1'b0;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    resp_en   = 1'b1;
    man_ready = 1'b0;
    wait_cfg  = 0;
    busy_cnt  = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({i_gnt, d_gnt, i_valid, d_valid, mem_req, mem_we}), 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch, zero wait states
    i_req  = 1'b1;
    i_addr = 32'h0000_0010;
    exp_i.push_back(32'h0000_0013);
    @(negedge clk);
    chk("fetch_gnt", 32'({i_gnt, d_gnt, mem_req, mem_we}), 32'b1010);
    chk("fetch_mem_addr", 32'(mem_addr), 32'd4);
    chk("fetch_valid_early", 32'(i_valid), 32'd0);
    i_req = 1'b0;
    @(negedge clk);
    chk("fetch_valid_t2", 32'(i_valid), 32'd1);
    chk("fetch_idle_t2", 32'({mem_req, i_gnt}), 32'd0);

    // Load with three wait states
    wait_cfg = 3;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0020;
    exp_d.push_back('{st: 1'b0, data: 32'hDEAD_BEEF});
    @(negedge clk);
    chk("load_gnt", 32'({d_gnt, i_gnt}), 32'b10);
    d_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("load_busy%0d", c), 32'({mem_req, mem_we, d_valid}), 32'b100);
      chk($sformatf("load_addr%0d", c), 32'(mem_addr), 32'd8);
      @(negedge clk);
    end
    chk("load_valid", 32'({d_valid, mem_req}), 32'b10);

    // Store: d_rdata keeps the previous load word
    wait_cfg = 0;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0040;
    d_wdata = 32'h1234_5678;
    exp_d.push_back('{st: 1'b1, data: 32'hDEAD_BEEF});
    @(negedge clk);
    chk("store_ctrl", 32'({d_gnt, mem_req, mem_we}), 32'b111);
    chk("store_addr", 32'(mem_addr), 32'd16);
    chk("store_wdata", mem_wdata, 32'h1234_5678);
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    chk("store_valid", 32'(d_valid), 32'd1);

    // Read back the stored word, misaligned address truncated
    d_req  = 1'b1;
    d_addr = 32'h0000_0043;
    exp_d.push_back('{st: 1'b0, data: 32'h1234_5678});
    @(negedge clk);
    chk("rdback_addr", 32'(mem_addr), 32'd16);
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    // Contention: D,D,D,D,I,D,D,D,D,I
    exp_order = 10'b10_0001_0000;
    i_req  = 1'b1;
    i_addr = 32'h0000_0000;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0004;
    for (int g = 0; g < 10; g++) begin
      if (exp_order[g]) exp_i.push_back(32'h0000_0093);
      else              exp_d.push_back('{st: 1'b0, data: 32'hCAFE_0001});
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(i_gnt || d_gnt) && n < 20);
      if (!(i_gnt || d_gnt)) begin
        checks++;
        failures++;
        $display("FAIL contention_timeout grant=%0d actual=none expected=grant", g);
        break;
      end
      got_i = i_gnt;
      chk($sformatf("order%0d", g), 32'({i_gnt, d_gnt}), exp_order[g] ? 32'b10 : 32'b01);
      if (g == 9) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
      if (got_i && g == 4) chk("streak_clear", 32'(dut.u_streak.cnt), 32'd0);
    end
    repeat (3) @(negedge clk);

    // Reset mid-access, memory never ready
    resp_en   = 1'b0;
    man_ready = 1'b0;
    d_req  = 1'b1;
    d_addr = 32'h0000_0020;
    @(negedge clk);
    chk("midrst_gnt", 32'({d_gnt, mem_req}), 32'b11);
    d_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_memreq", 32'({mem_req, d_valid}), 32'd0);
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    rst_n     = 1'b1;
    man_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("late_ready", 32'({d_valid, i_valid, mem_req}), 32'd0);
    man_ready = 1'b0;
    @(negedge clk);
    resp_en = 1'b1;
    i_req   = 1'b1;
    i_addr  = 32'h0000_0000;
    exp_i.push_back(32'h0000_0093);
    @(negedge clk);
    chk("post_rst_fetch", 32'({i_gnt, mem_req}), 32'b11);
    i_req = 1'b0;
    repeat (2) @(negedge clk);

    // mem_ready pulsed while idle
    resp_en   = 1'b0;
    man_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'({i_valid, d_valid, mem_req}), 32'd0);
    chk("idle_ready_state", 32'(dut.state), 32'(IDLE));
    man_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("exp_i_drained", 32'(exp_i.size()), 32'd0);
    chk("exp_d_drained", 32'(exp_d.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
